// File: rtl/canvas_pkg.sv
// Shared canvas geometry, the reader FSM state encoding, and the pixel record carried through the skid FIFO.
// Latency: none; this file holds only constants and types.
// Backpressure: not applicable.
package canvas_pkg;

  localparam int CANVAS_W      = 28;
  localparam int CANVAS_H      = 28;
  localparam int CANVAS_SIZE   = CANVAS_W * CANVAS_H;  // 784 cells
  localparam int CANVAS_ADDR_W = 10;
  localparam int TAG_W         = 5;                    // row/col tag width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // One pixel as it travels from the RAM read port to the classifier.
  typedef struct packed {
    logic             data;
    logic [TAG_W-1:0] row;
    logic [TAG_W-1:0] col;
    logic             last;
  } pix_t;

endpackage

// File: rtl/canvas_reader_if.sv
// Bundles the canvas RAM read port and the pixel stream toward the classifier.
// Latency: none; this is wiring only.
// Backpressure: pix_ready stalls the stream, and the RAM side has no stall.
// Ports:
//   rd_en, rd_addr, rd_data                                  RAM read port, with data one cycle after rd_en
//   pix_valid, pix_ready, pix_data, pix_row, pix_col, pix_last   pixel stream
// Modports: master = reader side, slave = RAM and classifier side.
interface canvas_reader_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic [4:0]        pix_row;
  logic [4:0]        pix_col;
  logic              pix_last;

  modport master (
    output rd_en, rd_addr, pix_valid, pix_data, pix_row, pix_col, pix_last,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_valid, pix_data, pix_row, pix_col, pix_last,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/canvas_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides.
// Latency: one cycle from push to out_vld.
// Backpressure: in_rdy drops when both entries are held, and the output holds stable until out_rdy.
// Ports: clk, rst (async active-low), in_vld/in_rdy/in_dat, out_vld/out_rdy/out_dat, count (current occupancy).
module canvas_skid_fifo #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0);
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/canvas_reader.sv
// Scans the canvas RAM in raster order on start and streams each pixel to the classifier with row and column tags.
// Latency: the first pixel_valid appears 3 cycles after the start edge when the canvas is free, followed by one pixel per cycle.
// Backpressure: reads are issued only when they are guaranteed a FIFO slot, so pix_ready may stall for any length of time.
// Ports: clk, rst (async active-low), start, canvas_busy, busy, done, pixel_count, bus (canvas_reader_if.master).
// Option: define CANVAS_READER_COUNT_EN to make pixel_count accumulate the painted pixels of each scan; otherwise it is tied to 0.
module canvas_reader
  import canvas_pkg::*;
#(
  parameter int W      = CANVAS_W,
  parameter int H      = CANVAS_H,
  parameter int ADDR_W = CANVAS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              canvas_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pixel_count,
  canvas_reader_if.master   bus
);
  state_t           state, state_nxt;
  logic [TAG_W-1:0] row, col;
  logic             at_last;
  logic             rd_en;
  logic             in_flight;
  logic [TAG_W-1:0] fl_row, fl_col;
  logic             fl_last;
  logic             credit_ok;
  logic [2:0]       occupancy;
  logic [1:0]       fifo_cnt;
  logic             fifo_in_rdy;
  logic             fifo_out_vld;
  logic             push_vld;
  logic             pop;
  pix_t             push_dat, pop_dat;

  assign at_last = (row == TAG_W'(H - 1)) && (col == TAG_W'(W - 1));
  assign pop     = fifo_out_vld & bus.pix_ready;

  // Every issued read must have a FIFO slot when its data lands a cycle later.
  // A pop in this cycle frees a slot in time for that data.
  assign occupancy = {1'b0, fifo_cnt} + {2'b0, in_flight};
  assign credit_ok = occupancy < (3'd2 + {2'b0, pop});

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = WAIT;
      WAIT:  if (!canvas_busy) state_nxt = FETCH;
      FETCH: begin
        if (!canvas_busy && credit_ok) begin
          rd_en = 1'b1;
          if (at_last) state_nxt = DRAIN;
        end
      end
      DRAIN: if (pop && pop_dat.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      in_flight <= 1'b0;
      fl_row    <= '0;
      fl_col    <= '0;
      fl_last   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= rd_en;
      done      <= (state == DRAIN) && pop && pop_dat.last;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (rd_en) begin
        // The read tags follow the data, so they are captured with the issue.
        fl_row  <= row;
        fl_col  <= col;
        fl_last <= at_last;
        if (col == TAG_W'(W - 1)) begin
          col <= '0;
          row <= (row == TAG_W'(H - 1)) ? '0 : row + TAG_W'(1);
        end else begin
          col <= col + TAG_W'(1);
        end
      end
    end
  end

  // The credit rule already guarantees space, and gating on in_rdy keeps a held entry from ever being overwritten.
  assign push_vld = in_flight & fifo_in_rdy;
  assign push_dat = '{data: bus.rd_data, row: fl_row, col: fl_col, last: fl_last};

  canvas_skid_fifo #(.WIDTH($bits(pix_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push_vld),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (push_dat),
    .out_vld (fifo_out_vld),
    .out_rdy (bus.pix_ready),
    .out_dat (pop_dat),
    .count   (fifo_cnt)
  );

  assign busy          = (state != IDLE);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(col);
  assign bus.pix_valid = fifo_out_vld;
  assign bus.pix_data  = pop_dat.data;
  assign bus.pix_row   = pop_dat.row;
  assign bus.pix_col   = pop_dat.col;
  assign bus.pix_last  = pop_dat.last;

`ifdef CANVAS_READER_COUNT_EN
  logic [ADDR_W-1:0] ones_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt <= '0;
    end else if (state == IDLE && start) begin
      ones_cnt <= '0;
    end else if (pop && pop_dat.data) begin
      ones_cnt <= ones_cnt + ADDR_W'(1);
    end
  end

  assign pixel_count = ones_cnt;
`else
  assign pixel_count = '0;
`endif

endmodule

// File: tb/tb_canvas_reader.sv
// Testbench for canvas_reader, driven with randomized back-pressure and canvas contents.
// Each scan is compared against a raster-order model of the canvas RAM.
// Checks cover ordering, credit limits, stall stability, done timing and reset behaviour.
module tb_canvas_reader;
  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       canvas_busy;
  logic       busy;
  logic       done;
  logic [9:0] pixel_count;

  canvas_reader_if #(.ADDR_W(10)) bus ();

  canvas_reader #(.W(28), .H(28), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .canvas_busy (canvas_busy),
    .busy        (busy),
    .done        (done),
    .pixel_count (pixel_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Canvas RAM model with 1-cycle read latency.
  logic ram [0:NPIX-1];
  always @(posedge clk)
    if (bus.rd_en && int'(bus.rd_addr) < NPIX) bus.rd_data <= ram[int'(bus.rd_addr)];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];
  int n_issued, n_xfer, n_done, done_cyc, first_vld_cyc, first_xfer_cyc, last_xfer_cyc;
  int order_viol, busy_viol, credit_viol, stall_viol, resume_addr;
  bit watch_resume, prev_stall;
  logic [11:0] prev_out;

  task automatic mon_clear();
    got_q.delete();
    n_issued = 0; n_xfer = 0; n_done = 0; done_cyc = -1;
    first_vld_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    order_viol = 0; busy_viol = 0; credit_viol = 0; stall_viol = 0;
    resume_addr = -1; watch_resume = 0; prev_stall = 0; prev_out = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      logic        xfer;
      logic [11:0] cur;
      xfer = bus.pix_valid & bus.pix_ready;
      cur  = {bus.pix_data, bus.pix_row, bus.pix_col, bus.pix_last};
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != n_issued) order_viol++;
        if (canvas_busy) busy_viol++;
        // Reads outstanding after this edge must fit the 2-entry buffer.
        if (n_issued - n_xfer - (xfer ? 1 : 0) >= 2) credit_viol++;
        if (watch_resume) begin
          resume_addr  = int'(bus.rd_addr);
          watch_resume = 0;
        end
        n_issued++;
      end
      if (prev_stall && (!bus.pix_valid || cur != prev_out)) stall_viol++;
      prev_stall = bus.pix_valid & ~bus.pix_ready;
      prev_out   = cur;
      if (bus.pix_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (xfer) begin
        got_q.push_back(cur);
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        n_xfer++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Stimulus
  int  start_cyc;
  bit  pulsed;
  int  hold;

  task automatic step(input int pct, input int mode);
    @(posedge clk); #1;
    bus.pix_ready = ($urandom_range(99) < pct);
    if (mode == 2) begin
      if (!pulsed && n_issued >= 400) begin
        canvas_busy  = 1'b1;
        hold         = 10;
        pulsed       = 1'b1;
        watch_resume = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) canvas_busy = 1'b0;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_scan(input int pct, input int mode, input string tag);
    int exp_ones, got_ones, bad;
    mon_clear();
    exp_q.delete();
    exp_ones = 0;
    for (int i = 0; i < NPIX; i++) begin
      logic [4:0] r, c;
      r = 5'(i / 28);
      c = 5'(i % 28);
      exp_q.push_back({ram[i], r, c, (i == NPIX - 1)});
      exp_ones += int'(ram[i]);
    end
    pulsed = 0;
    hold   = 0;
    if (mode == 1) canvas_busy = 1'b1;
    pulse_start();
    if (mode == 1) begin
      repeat (50) step(pct, 0);
      chk({tag, ":busy_in_wait"}, int'(busy), 1);
      chk({tag, ":reads_while_busy"}, n_issued, 0);
      canvas_busy = 1'b0;
    end
    for (int c = 0; c < 20000 && n_done == 0; c++) step(pct, mode);
    repeat (5) step(pct, mode);

    chk({tag, ":xfers"}, got_q.size(), NPIX);
    bad = 0;
    got_ones = 0;
    for (int i = 0; i < got_q.size() && i < NPIX; i++) begin
      if (got_q[i] != exp_q[i]) bad++;
      got_ones += int'(got_q[i][11]);
    end
    chk({tag, ":seq_mismatch"}, bad, 0);
    chk({tag, ":ones_seen"}, got_ones, exp_ones);
    chk({tag, ":done_pulses"}, n_done, 1);
    chk({tag, ":done_after_last"}, done_cyc, last_xfer_cyc + 1);
    chk({tag, ":busy_after"}, int'(busy), 0);
    chk({tag, ":reads_issued"}, n_issued, NPIX);
    chk({tag, ":read_order"}, order_viol, 0);
    chk({tag, ":credit"}, credit_viol, 0);
    chk({tag, ":rd_while_busy"}, busy_viol, 0);
    chk({tag, ":stall_stable"}, stall_viol, 0);
`ifdef CANVAS_READER_COUNT_EN
    chk({tag, ":pixel_count"}, int'(pixel_count), exp_ones);
`else
    chk({tag, ":pixel_count"}, int'(pixel_count), 0);
`endif
    if (mode == 0 && pct == 100) begin
      chk({tag, ":first_valid_lat"}, first_vld_cyc - start_cyc, 3);
      chk({tag, ":no_bubbles"}, last_xfer_cyc - first_xfer_cyc, NPIX - 1);
    end
    if (mode == 2) chk({tag, ":resume_addr"}, resume_addr, 400);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; canvas_busy = 1'b0; bus.pix_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) ram[i] = 1'b0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({busy, done, bus.rd_en, bus.pix_valid, bus.pix_data,
                              bus.pix_row, bus.pix_col, bus.pix_last}), 0);
    chk("reset_pixel_count", int'(pixel_count), 0);
    rst = 1'b1;

    run_scan(100, 0, "empty");

    ram[0] = 1'b1; ram[29] = 1'b1; ram[783] = 1'b1;
    run_scan(100, 0, "three");
    run_scan(30, 0, "stall30");

    for (int i = 0; i < NPIX; i++) ram[i] = logic'($urandom_range(1));
    run_scan(70, 1, "busy_start");

    for (int i = 0; i < NPIX; i++) ram[i] = logic'($urandom_range(1));
    run_scan(100, 2, "busy_mid");

    // Abort a scan with reset after 200 pixels.
    mon_clear();
    pulse_start();
    for (int c = 0; c < 2000 && got_q.size() < 200; c++) step(100, 0);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", int'({busy, done, bus.rd_en, bus.pix_valid, bus.pix_data,
                               bus.pix_row, bus.pix_col, bus.pix_last}), 0);
    chk("midrst_pixel_count", int'(pixel_count), 0);
    chk("midrst_reached_200", (got_q.size() >= 200) ? 1 : 0, 1);
    repeat (5) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    rst = 1'b1;
    run_scan(30, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
